// File: rtl/programmable_delay_line_if.sv
// programmable_delay_line_if: sample, valid and status bundle for the programmable delay line
interface programmable_delay_line_if #(
  parameter int N = 5,
  parameter int CH = 2,
  parameter int MAX_DELAY = 16,
  parameter int DW = $clog2(MAX_DELAY + 1)
);
  logic ce;
  logic [DW-1:0] delay;
  logic [CH*N-1:0] idata;
  logic ivalid;
  logic [CH*N-1:0] odata;
  logic ovalid;
  logic locked;
  logic delay_err;
  modport master (output ce, delay, idata, ivalid, input odata, ovalid, locked, delay_err);
  modport slave (input ce, delay, idata, ivalid, output odata, ovalid, locked, delay_err);
endinterface

// File: rtl/programmable_delay_line.sv
// programmable_delay_line: multi-channel shift chain with run-time tap, valid flush and lock tracking
module programmable_delay_line #(
  parameter int N = 5,
  parameter int CH = 2,
  parameter int MAX_DELAY = 16,
  localparam int DW = $clog2(MAX_DELAY + 1)
) (
  input logic clk,
  input logic rst,
  programmable_delay_line_if.slave bus
);
  localparam int W = CH * N;
  localparam int AW = MAX_DELAY > 1 ? $clog2(MAX_DELAY) : 1;
  localparam logic [DW-1:0] MAXD = DW'(MAX_DELAY);
  typedef enum logic {FILL, LOCKED} state_t;
  state_t state, state_n;
  logic [W-1:0] sd [MAX_DELAY];
  logic [MAX_DELAY-1:0] sv;
  logic [DW-1:0] active_delay, fill_cnt, fill_cnt_n, req;
  logic [AW-1:0] tap;
  logic change;
  assign req = bus.delay > MAXD ? MAXD : bus.delay;
  assign change = req != active_delay;
  assign tap = AW'(active_delay - 1'b1);
  // a new delay flushes only valid bits; the sample arriving on that edge still enters as valid
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < MAX_DELAY; i++) sd[i] <= '0;
      sv <= '0;
      active_delay <= '0;
      bus.delay_err <= 1'b0;
    end else if (bus.ce) begin
      sd[0] <= bus.idata;
      for (int i = 1; i < MAX_DELAY; i++) sd[i] <= sd[i-1];
      sv <= ((change ? '0 : sv) << 1) | MAX_DELAY'(bus.ivalid);
      active_delay <= req;
      bus.delay_err <= bus.delay > MAXD;
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= FILL;
      fill_cnt <= '0;
    end else begin
      state <= state_n;
      fill_cnt <= fill_cnt_n;
    end
  always_comb begin
    fill_cnt_n = !bus.ce ? fill_cnt : change ? '0 : state == FILL ? fill_cnt + 1'b1 : fill_cnt;
    state_n = !bus.ce ? state : change ? FILL : fill_cnt_n >= active_delay ? LOCKED : state;
  end
  assign bus.odata = active_delay == '0 ? bus.idata : sd[tap];
  assign bus.ovalid = active_delay == '0 ? bus.ivalid : sv[tap];
  assign bus.locked = state == LOCKED;
endmodule

// File: tb/tb_programmable_delay_line.sv
// tb_programmable_delay_line: directed stimulus with a due-edge scoreboard and a small lock/error model
module tb_programmable_delay_line;
  localparam int N = 5, CH = 2, MAXD = 16, DW = 5, W = CH * N;
  typedef struct {logic [W-1:0] d; int due;} ent_t;
  logic clk = 1'b0, rst = 1'b1;
  int ncmp = 0, nerr = 0;
  ent_t q[$];
  int act = 0, fc = 0, ecnt = 0;
  bit lk = 1'b0, er = 1'b0, hv = 1'b0;
  logic [W-1:0] hd = '0;
  programmable_delay_line_if #(.N(N), .CH(CH), .MAX_DELAY(MAXD)) bus ();
  programmable_delay_line #(.N(N), .CH(CH), .MAX_DELAY(MAXD)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] mk(input int i);
    mk = {5'(i * 3 + 1), 5'(i)};
  endfunction
  task automatic cyc(input logic c, input logic v, input logic [W-1:0] d, input logic [DW-1:0] dl, input logic r);
    int req;
    bit ev;
    bus.ce = c; bus.ivalid = v; bus.idata = d; bus.delay = dl; rst = r;
    #1;
    if (!r && act == 0) begin
      chk("bypass_data", bus.odata, d);
      chk("bypass_valid", W'(bus.ovalid), W'(v));
    end
    if (r) begin
      q.delete(); act = 0; fc = 0; lk = 0; er = 0; hv = 0;
    end else if (c) begin
      er = dl > MAXD;
      req = dl > MAXD ? MAXD : int'(dl);
      ecnt++;
      if (req != act) begin
        q.delete(); act = req; fc = 0; lk = 0;
      end else if (!lk) begin
        if (fc + 1 >= act) lk = 1;
        fc++;
      end
      if (v && act > 0) q.push_back('{d, ecnt + act - 1});
    end
    @(posedge clk);
    #1;
    chk("locked", W'(bus.locked), W'(lk));
    chk("delay_err", W'(bus.delay_err), W'(er));
    if (r) chk("ovalid_rst", W'(bus.ovalid), W'(v));
    else if (c && act > 0) begin
      ev = q.size() > 0 && q[0].due == ecnt;
      chk("ovalid", W'(bus.ovalid), W'(ev));
      hv = ev;
      if (ev) begin
        hd = q[0].d;
        chk("odata", bus.odata, hd);
        void'(q.pop_front());
      end
    end else if (!c && act > 0) begin
      chk("hold_valid", W'(bus.ovalid), W'(hv));
      if (hv) chk("hold_data", bus.odata, hd);
    end
  endtask
  initial begin
    cyc(1, 0, '0, 5'd4, 1);
    cyc(0, 0, '0, 5'd4, 1);
    for (int i = 1; i <= 12; i++) cyc(1, 1, mk(i), 5'd4, 0);
    for (int i = 0; i < 16; i++) cyc(i % 2 == 0, 1, mk(i + 7), 5'd3, 0);
    cyc(0, 1, mk(40), 5'd6, 0);
    cyc(0, 1, mk(41), 5'd6, 0);
    for (int i = 0; i < 10; i++) cyc(1, i % 3 != 1, mk(50 + i), 5'd5, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, mk(70 + i), 5'd2, 0);
    cyc(1, 1, {5'h0A, 5'h1F}, 5'd0, 0);
    cyc(1, 1, {5'h0A, 5'h1F}, 5'd0, 0);
    cyc(1, 0, {5'h15, 5'h03}, 5'd0, 0);
    cyc(0, 1, {5'h11, 5'h0C}, 5'd0, 0);
    for (int i = 0; i < 22; i++) cyc(1, 1, mk(90 + i), 5'd20, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, mk(120 + i), 5'd16, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, mk(130 + i), 5'd4, 0);
    cyc(1, 0, mk(200), 5'd4, 1);
    for (int i = 0; i < 8; i++) cyc(1, 1, mk(140 + i), 5'd4, 0);
    cyc(1, 1, mk(160), 5'd1, 0);
    cyc(1, 0, mk(161), 5'd1, 0);
    cyc(1, 1, mk(162), 5'd1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
